// File: rtl/mem_access_stage_pkg.sv
// ==========================================================================
// mem_access_stage_pkg : load/store codes, FSM states and pipeline records
// Revision 1.0
// ==========================================================================
`default_nettype none

package mem_access_stage_pkg;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;
   localparam logic [2:0] LOAD_DEF = 3'b111;

   localparam logic [1:0] STORE_SB  = 2'b00;
   localparam logic [1:0] STORE_SH  = 2'b01;
   localparam logic [1:0] STORE_SW  = 2'b10;
   localparam logic [1:0] STORE_DEF = 2'b11;

   localparam logic [31:0] ZERO_32BIT = 32'h0000_0000;

   typedef enum logic {
      MEM_IDLE   = 1'b0,
      MEM_ACCESS = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        wb_reg_file;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  load_type;
      logic [1:0]  store_type;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        reg_file;
      logic        misaligned;
      logic        bus_error;
   } mem_wb_t;

   // Words need addr[1:0]==0, halfwords need addr[0]==0; bytes never fault.
   function automatic logic access_misaligned(
      input logic       is_load,
      input logic [2:0] load_type,
      input logic [1:0] store_type,
      input logic [1:0] addr_lo
   );
      logic mis;
      mis = 1'b0;
      if (is_load) begin
         if (load_type == LOAD_LW)
            mis = (addr_lo != 2'b00);
         else if ((load_type == LOAD_LH) || (load_type == LOAD_LHU))
            mis = addr_lo[0];
      end else begin
         if (store_type == STORE_SW)
            mis = (addr_lo != 2'b00);
         else if (store_type == STORE_SH)
            mis = addr_lo[0];
      end
      return mis;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ==========================================================================
// mem_lane_align : byte-lane steering for stores, lane select/extension for loads
// Revision 1.0
// ==========================================================================
`default_nettype none

module mem_lane_align
   import mem_access_stage_pkg::*;
(
   input  logic        is_load_i,
   input  logic [2:0]  load_type_i,
   input  logic [1:0]  store_type_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_data_o,
   output logic        misaligned_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (addr_lo_i)
         2'd0:    w_byte = rdata_i[7:0];
         2'd1:    w_byte = rdata_i[15:8];
         2'd2:    w_byte = rdata_i[23:16];
         default: w_byte = rdata_i[31:24];
      endcase
      w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      case (load_type_i)
         LOAD_LB:  load_data_o = {{24{w_byte[7]}}, w_byte};
         LOAD_LBU: load_data_o = {24'h0, w_byte};
         LOAD_LH:  load_data_o = {{16{w_half[15]}}, w_half};
         LOAD_LHU: load_data_o = {16'h0, w_half};
         default:  load_data_o = rdata_i;
      endcase
   end

   // Store data is replicated across lanes so the enables alone pick the target bytes.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = ZERO_32BIT;
      if (!is_load_i) begin
         case (store_type_i)
            STORE_SB: begin
               be_o    = 4'b0001 << addr_lo_i;
               wdata_o = {4{store_data_i[7:0]}};
            end
            STORE_SH: begin
               be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
               wdata_o = {2{store_data_i[15:0]}};
            end
            STORE_SW: begin
               be_o    = 4'b1111;
               wdata_o = store_data_i;
            end
            default: begin
               be_o    = 4'b0000;
               wdata_o = ZERO_32BIT;
            end
         endcase
      end
   end

   assign misaligned_o = access_misaligned(is_load_i, load_type_i, store_type_i, addr_lo_i);

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ==========================================================================
// mem_access_stage : EX/MEM and MEM/WB registers with a single-outstanding dmem access
// Revision 1.0
// ==========================================================================
`default_nettype none

module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int XLEN           = 32
)(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] ex_result_alu,
   input  logic [XLEN-1:0] ex_op2_selected,
   input  logic [4:0]      ex_wb_rd,
   input  logic            ex_wb_reg_file,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [2:0]      ex_load_type,
   input  logic [1:0]      ex_store_type,
   input  logic            ex_flush,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic [XLEN-1:0] dmem_rdata,
   input  logic            dmem_ack,
   output logic            mem_stall,
   output logic [XLEN-1:0] data_forward_mem,
   output logic [4:0]      mem_rd,
   output logic            mem_reg_file,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_reg_file,
   output logic            misaligned_exc,
   output logic            bus_error
);

   localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ex_mem_t          ex_mem_q, ex_mem_d;
   mem_wb_t          mem_wb_q, mem_wb_d;

   logic        w_ex_is_load, w_ex_is_store, w_cap_mem_op, w_timeout;
   logic        w_is_load_q, w_is_store_q, w_mem_op_q, w_wbe_q, w_mis_q;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_load_data;

   // Both read and write set is treated as a load; DEF codes fall through as ALU ops.
   assign w_ex_is_load  = ex_mem_read && (ex_load_type != LOAD_DEF);
   assign w_ex_is_store = ex_mem_write && !ex_mem_read && (ex_store_type != STORE_DEF);
   assign w_cap_mem_op  = !mem_stall && !ex_flush && (w_ex_is_load || w_ex_is_store) &&
                          !access_misaligned(w_ex_is_load, ex_load_type, ex_store_type,
                                             ex_result_alu[1:0]);

   assign w_is_load_q  = ex_mem_q.mem_read && (ex_mem_q.load_type != LOAD_DEF);
   assign w_is_store_q = ex_mem_q.mem_write && !ex_mem_q.mem_read &&
                         (ex_mem_q.store_type != STORE_DEF);
   assign w_mem_op_q   = w_is_load_q || w_is_store_q;
   assign w_wbe_q      = ex_mem_q.wb_reg_file && (ex_mem_q.rd != 5'd0);

   mem_lane_align u_lane (
      .is_load_i    (w_is_load_q),
      .load_type_i  (ex_mem_q.load_type),
      .store_type_i (ex_mem_q.store_type),
      .addr_lo_i    (ex_mem_q.alu[1:0]),
      .store_data_i (ex_mem_q.op2),
      .rdata_i      (dmem_rdata),
      .be_o         (w_be),
      .wdata_o      (w_wdata),
      .load_data_o  (w_load_data),
      .misaligned_o (w_mis_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      w_timeout = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (w_cap_mem_op) begin
               state_d = MEM_ACCESS;
               cnt_d   = '0;
            end
         end
         MEM_ACCESS: begin
            if (dmem_ack) begin
               state_d = w_cap_mem_op ? MEM_ACCESS : MEM_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = MEM_IDLE;
               w_timeout = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = MEM_IDLE;
      endcase
   end

   always_comb begin
      ex_mem_d = ex_mem_q;
      if (!mem_stall) begin
         if (ex_flush) begin
            ex_mem_d = '0;
         end else begin
            ex_mem_d.alu         = ex_result_alu;
            ex_mem_d.op2         = ex_op2_selected;
            ex_mem_d.rd          = ex_wb_rd;
            ex_mem_d.wb_reg_file = ex_wb_reg_file;
            ex_mem_d.mem_read    = ex_mem_read;
            ex_mem_d.mem_write   = ex_mem_write;
            ex_mem_d.load_type   = ex_load_type;
            ex_mem_d.store_type  = ex_store_type;
         end
      end
   end

   // A mem op seen in IDLE was either misaligned or already aborted by timeout: no write-back.
   always_comb begin
      mem_wb_d           = '0;
      mem_wb_d.bus_error = w_timeout;
      if (!mem_stall) begin
         mem_wb_d.rd = ex_mem_q.rd;
         if (state_q == MEM_ACCESS) begin
            mem_wb_d.data     = w_load_data;
            mem_wb_d.reg_file = w_is_load_q && w_wbe_q;
         end else if (w_mem_op_q) begin
            mem_wb_d.misaligned = w_mis_q;
         end else begin
            mem_wb_d.data     = ex_mem_q.alu;
            mem_wb_d.reg_file = w_wbe_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= MEM_IDLE;
         cnt_q    <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign dmem_req   = (state_q == MEM_ACCESS);
   assign dmem_we    = dmem_req && w_is_store_q;
   assign dmem_addr  = dmem_req ? {ex_mem_q.alu[31:2], 2'b00} : ZERO_32BIT;
   assign dmem_wdata = dmem_req ? w_wdata : ZERO_32BIT;
   assign dmem_be    = dmem_req ? w_be : 4'b0000;
   assign mem_stall  = (state_q == MEM_ACCESS) && !dmem_ack;

   assign data_forward_mem = ex_mem_q.alu;
   assign mem_rd           = ex_mem_q.rd;
   assign mem_reg_file     = w_wbe_q;

   assign wb_data        = mem_wb_q.data;
   assign wb_rd          = mem_wb_q.rd;
   assign wb_reg_file    = mem_wb_q.reg_file;
   assign misaligned_exc = mem_wb_q.misaligned;
   assign bus_error      = mem_wb_q.bus_error;

endmodule

`default_nettype wire
